// File: rtl/stm_segment_scheduler.sv
// stm_segment_scheduler
// Chooses which of the two STM segments is active, steps its sample index on
// every ADVANCE tick, counts repeats, and decides when a requested segment
// swap takes effect (on a sync-index wrap, a system-time threshold, a GPIO
// edge, or immediately).
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   SYS_TIME           free-running system time (64-bit)
//   ADVANCE            one-cycle sample tick
//   UPDATE_SETTINGS    latch REQ_SEGMENT/TRANSITION_*/CYCLE/REP as a pending request
//   GPIO_IN            asynchronous external triggers
//   SEGMENT, IDX       active segment and sample index (BRAM read address)
//   IDX_VALID          one-cycle pulse when SEGMENT/IDX were just updated
//   STOP               active segment has played all its repeats
//   PENDING            a swap request is waiting for its trigger
module stm_segment_scheduler #(
    parameter int unsigned IDX_W  = 13,
    parameter int unsigned GPIO_N = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [63:0]       SYS_TIME,
    input  logic              ADVANCE,
    input  logic              UPDATE_SETTINGS,
    input  logic              REQ_SEGMENT,
    input  logic [1:0]        TRANSITION_MODE,
    input  logic [63:0]       TRANSITION_VALUE,
    input  logic [IDX_W-1:0]  CYCLE,
    input  logic [31:0]       REP,
    input  logic [GPIO_N-1:0] GPIO_IN,
    output logic              SEGMENT,
    output logic [IDX_W-1:0]  IDX,
    output logic              IDX_VALID,
    output logic              STOP,
    output logic              PENDING
);

    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    localparam logic [1:0] MODE_SYNC_IDX  = 2'd0;
    localparam logic [1:0] MODE_SYS_TIME  = 2'd1;
    localparam logic [1:0] MODE_GPIO      = 2'd2;
    localparam logic [1:0] MODE_IMMEDIATE = 2'd3;

    localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;

    logic [0:0]        state_q, state_d;
    logic              seg_q, seg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              idx_valid_q, idx_valid_d;
    logic              stop_q, stop_d;
    logic [31:0]       loop_q, loop_d;
    logic [IDX_W-1:0]  cycle_q, cycle_d;
    logic [31:0]       rep_q, rep_d;

    logic              pend_q, pend_d;
    logic              pend_seg_q, pend_seg_d;
    logic [1:0]        pend_mode_q, pend_mode_d;
    logic [63:0]       pend_value_q, pend_value_d;
    logic [IDX_W-1:0]  pend_cycle_q, pend_cycle_d;
    logic [31:0]       pend_rep_q, pend_rep_d;

    logic [GPIO_N-1:0] gpio_s1_q, gpio_s1_d;
    logic [GPIO_N-1:0] gpio_s2_q, gpio_s2_d;
    logic [GPIO_N-1:0] gpio_s3_q, gpio_s3_d;
    logic              edge_seen_q, edge_seen_d;

    logic [3:0]        gpio_rise_c;
    logic              swap_c;

    // Next-state logic: GPIO sync, pending request capture, swap and sequencing.
    always_comb begin
        state_d      = state_q;
        seg_d        = seg_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        stop_d       = stop_q;
        loop_d       = loop_q;
        cycle_d      = cycle_q;
        rep_d        = rep_q;
        pend_d       = pend_q;
        pend_seg_d   = pend_seg_q;
        pend_mode_d  = pend_mode_q;
        pend_value_d = pend_value_q;
        pend_cycle_d = pend_cycle_q;
        pend_rep_d   = pend_rep_q;
        edge_seen_d  = edge_seen_q;

        gpio_s1_d   = GPIO_IN;
        gpio_s2_d   = gpio_s1_q;
        gpio_s3_d   = gpio_s2_q;
        gpio_rise_c = 4'(gpio_s2_q & ~gpio_s3_q);

        // The selected GPIO edge is remembered until the swap consumes it.
        if (pend_q && (pend_mode_q == MODE_GPIO) && gpio_rise_c[pend_value_q[1:0]]) begin
            edge_seen_d = 1'b1;
        end

        unique case (pend_mode_q)
            MODE_SYNC_IDX:  swap_c = ADVANCE && ((state_q == ST_STOPPED) || (idx_q == cycle_q));
            MODE_SYS_TIME:  swap_c = ADVANCE && (SYS_TIME >= pend_value_q);
            MODE_GPIO:      swap_c = ADVANCE && edge_seen_q;
            MODE_IMMEDIATE: swap_c = 1'b1;
            default:        swap_c = 1'b0;
        endcase
        swap_c = swap_c && pend_q;

        // A new request always overwrites the pending one; on a coinciding
        // swap the old fields are consumed below before these take over.
        if (UPDATE_SETTINGS) begin
            pend_d       = 1'b1;
            pend_seg_d   = REQ_SEGMENT;
            pend_mode_d  = TRANSITION_MODE;
            pend_value_d = TRANSITION_VALUE;
            pend_cycle_d = CYCLE;
            pend_rep_d   = REP;
            edge_seen_d  = 1'b0;
        end

        if (swap_c) begin
            state_d     = ST_RUN;
            seg_d       = pend_seg_q;
            idx_d       = '0;
            idx_valid_d = 1'b1;
            stop_d      = 1'b0;
            loop_d      = '0;
            cycle_d     = pend_cycle_q;
            rep_d       = pend_rep_q;
            pend_d      = UPDATE_SETTINGS;
            if (!UPDATE_SETTINGS) begin
                edge_seen_d = 1'b0;
            end
        end else if ((state_q == ST_RUN) && ADVANCE) begin
            if (idx_q < cycle_q) begin
                idx_d       = idx_q + IDX_W'(1);
                idx_valid_d = 1'b1;
            end else if ((rep_q != REP_INFINITE) && (loop_q == rep_q)) begin
                // Last repeat done: hold IDX at the final sample.
                stop_d  = 1'b1;
                state_d = ST_STOPPED;
            end else begin
                idx_d       = '0;
                idx_valid_d = 1'b1;
                if (rep_q != REP_INFINITE) begin
                    loop_d = loop_q + 32'd1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_STOPPED;
            seg_q        <= 1'b0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            stop_q       <= 1'b1;
            loop_q       <= '0;
            cycle_q      <= '0;
            rep_q        <= '0;
            pend_q       <= 1'b0;
            pend_seg_q   <= 1'b0;
            pend_mode_q  <= MODE_SYNC_IDX;
            pend_value_q <= '0;
            pend_cycle_q <= '0;
            pend_rep_q   <= '0;
            gpio_s1_q    <= '0;
            gpio_s2_q    <= '0;
            gpio_s3_q    <= '0;
            edge_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            stop_q       <= stop_d;
            loop_q       <= loop_d;
            cycle_q      <= cycle_d;
            rep_q        <= rep_d;
            pend_q       <= pend_d;
            pend_seg_q   <= pend_seg_d;
            pend_mode_q  <= pend_mode_d;
            pend_value_q <= pend_value_d;
            pend_cycle_q <= pend_cycle_d;
            pend_rep_q   <= pend_rep_d;
            gpio_s1_q    <= gpio_s1_d;
            gpio_s2_q    <= gpio_s2_d;
            gpio_s3_q    <= gpio_s3_d;
            edge_seen_q  <= edge_seen_d;
        end
    end

    assign SEGMENT   = seg_q;
    assign IDX       = idx_q;
    assign IDX_VALID = idx_valid_q;
    assign STOP      = stop_q;
    assign PENDING   = pend_q;

endmodule

// File: tb/tb_stm_segment_scheduler.sv
// Directed bench for stm_segment_scheduler: each step drives inputs, then
// compares {SEGMENT, IDX, IDX_VALID, STOP, PENDING} against hand-derived values.
module tb_stm_segment_scheduler;

    localparam logic [1:0]  M_SYNC = 2'd0;
    localparam logic [1:0]  M_SYS  = 2'd1;
    localparam logic [1:0]  M_GPIO = 2'd2;
    localparam logic [1:0]  M_IMM  = 2'd3;
    localparam logic [31:0] INF    = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [63:0] SYS_TIME;
    logic        ADVANCE;
    logic        UPDATE_SETTINGS;
    logic        REQ_SEGMENT;
    logic [1:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [12:0] CYCLE;
    logic [31:0] REP;
    logic [3:0]  GPIO_IN;
    logic        SEGMENT;
    logic [12:0] IDX;
    logic        IDX_VALID;
    logic        STOP;
    logic        PENDING;

    int checks   = 0;
    int failures = 0;

    stm_segment_scheduler #(.IDX_W(13), .GPIO_N(4)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .SYS_TIME         (SYS_TIME),
        .ADVANCE          (ADVANCE),
        .UPDATE_SETTINGS  (UPDATE_SETTINGS),
        .REQ_SEGMENT      (REQ_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .CYCLE            (CYCLE),
        .REP              (REP),
        .GPIO_IN          (GPIO_IN),
        .SEGMENT          (SEGMENT),
        .IDX              (IDX),
        .IDX_VALID        (IDX_VALID),
        .STOP             (STOP),
        .PENDING          (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic adv();
        ADVANCE = 1'b1;
        tick();
        ADVANCE = 1'b0;
    endtask

    task automatic set_req(input logic seg, input logic [1:0] mode, input logic [63:0] val,
                           input logic [12:0] cyc, input logic [31:0] rep);
        REQ_SEGMENT      = seg;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = val;
        CYCLE            = cyc;
        REP              = rep;
    endtask

    task automatic upd(input logic seg, input logic [1:0] mode, input logic [63:0] val,
                       input logic [12:0] cyc, input logic [31:0] rep);
        set_req(seg, mode, val, cyc, rep);
        UPDATE_SETTINGS = 1'b1;
        tick();
        UPDATE_SETTINGS = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic seg, input logic [12:0] idx,
                              input logic vld, input logic stp, input logic pnd);
        logic [16:0] obs;
        logic [16:0] exp;
        obs = {SEGMENT, IDX, IDX_VALID, STOP, PENDING};
        exp = {seg, idx, vld, stp, pnd};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed seg=%0d idx=%0d vld=%0d stop=%0d pend=%0d required seg=%0d idx=%0d vld=%0d stop=%0d pend=%0d",
                   tag, SEGMENT, IDX, IDX_VALID, STOP, PENDING, seg, idx, vld, stp, pnd);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        SYS_TIME = 64'd0;
        ADVANCE = 1'b0;
        UPDATE_SETTINGS = 1'b0;
        GPIO_IN = 4'd0;
        set_req(1'b0, M_SYNC, 64'd0, 13'd0, 32'd0);
        idle(2);
        expect_out("reset", 1'b0, 13'd0, 1'b0, 1'b1, 1'b0);
        RST_N = 1'b1;
        tick();

        // Stopped with nothing pending: ADVANCE changes nothing.
        adv();
        expect_out("idle_adv", 1'b0, 13'd0, 1'b0, 1'b1, 1'b0);

        // Segment 0, SYNC_IDX, cycle 15, infinite; ADVANCE every 8 cycles.
        upd(1'b0, M_SYNC, 64'd0, 13'd15, INF);
        expect_out("seg0_pending", 1'b0, 13'd0, 1'b0, 1'b1, 1'b1);
        adv();
        expect_out("seg0_start", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("seg0_valid_drop", 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 100; w++) begin
            for (int i = 1; i <= 16; i++) begin
                idle(7);
                adv();
                expect_out("seg0_run", 1'b0, 13'(i % 16), 1'b1, 1'b0, 1'b0);
            end
        end

        // SYNC_IDX swap to segment 1 (cycle 3, rep 0) waits for the wrap from 15.
        for (int i = 1; i <= 5; i++) adv();
        upd(1'b1, M_SYNC, 64'd0, 13'd3, 32'd0);
        expect_out("sync_pending", 1'b0, 13'd5, 1'b0, 1'b0, 1'b1);
        for (int i = 6; i <= 15; i++) adv();
        expect_out("sync_at_15", 1'b0, 13'd15, 1'b1, 1'b0, 1'b1);
        adv();
        expect_out("sync_swap", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            adv();
            expect_out("seg1_run", 1'b1, 13'(i), 1'b1, 1'b0, 1'b0);
        end
        adv();
        expect_out("seg1_finish", 1'b1, 13'd3, 1'b0, 1'b1, 1'b0);
        adv();
        expect_out("seg1_held", 1'b1, 13'd3, 1'b0, 1'b1, 1'b0);

        // SYS_TIME threshold 1000; segment 0 with cycle 1, rep 1.
        upd(1'b0, M_SYS, 64'd1000, 13'd1, 32'd1);
        expect_out("sys_pending", 1'b1, 13'd3, 1'b0, 1'b1, 1'b1);
        SYS_TIME = 64'd990;
        adv();
        expect_out("sys_990", 1'b1, 13'd3, 1'b0, 1'b1, 1'b1);
        SYS_TIME = 64'd999;
        adv();
        expect_out("sys_999", 1'b1, 13'd3, 1'b0, 1'b1, 1'b1);
        SYS_TIME = 64'd1000;
        idle(2);
        expect_out("sys_no_adv", 1'b1, 13'd3, 1'b0, 1'b1, 1'b1);
        adv();
        expect_out("sys_swap", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("rep1_a1", 1'b0, 13'd1, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("rep1_wrap", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("rep1_b1", 1'b0, 13'd1, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("rep1_finish", 1'b0, 13'd1, 1'b0, 1'b1, 1'b0);

        // GPIO trigger on input 2; segment 1 with cycle 0, rep 2.
        upd(1'b1, M_GPIO, 64'd2, 13'd0, 32'd2);
        expect_out("gpio_pending", 1'b0, 13'd1, 1'b0, 1'b1, 1'b1);
        GPIO_IN = 4'b0010;
        tick();
        GPIO_IN = 4'b0000;
        idle(6);
        adv();
        expect_out("gpio1_ignored", 1'b0, 13'd1, 1'b0, 1'b1, 1'b1);
        GPIO_IN = 4'b0100;
        tick();
        GPIO_IN = 4'b0000;
        idle(6);
        expect_out("gpio2_wait_adv", 1'b0, 13'd1, 1'b0, 1'b1, 1'b1);
        adv();
        expect_out("gpio_swap", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("cyc0_loop1", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("cyc0_loop2", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("cyc0_finish", 1'b1, 13'd0, 1'b0, 1'b1, 1'b0);

        // IMMEDIATE swap mid-segment at IDX 7.
        upd(1'b0, M_SYNC, 64'd0, 13'd15, INF);
        adv();
        expect_out("imm_base_start", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) adv();
        upd(1'b1, M_IMM, 64'd0, 13'd9, INF);
        expect_out("imm_pending", 1'b0, 13'd7, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("imm_swap", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("imm_after", 1'b1, 13'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back requests: last one (segment 0, cycle 2) wins.
        upd(1'b1, M_SYNC, 64'd0, 13'd5, INF);
        upd(1'b0, M_SYNC, 64'd0, 13'd2, INF);
        expect_out("b2b_pending", 1'b1, 13'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) adv();
        expect_out("b2b_at_9", 1'b1, 13'd9, 1'b1, 1'b0, 1'b1);
        adv();
        expect_out("b2b_swap", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        adv();
        expect_out("b2b_idx2", 1'b0, 13'd2, 1'b1, 1'b0, 1'b0);
        adv();
        expect_out("b2b_wrap", 1'b0, 13'd0, 1'b1, 1'b0, 1'b0);

        // UPDATE_SETTINGS on the swap-triggering ADVANCE: old executes, new queues.
        upd(1'b0, M_SYNC, 64'd0, 13'd3, INF);
        adv();
        adv();
        expect_out("coinc_before", 1'b0, 13'd2, 1'b1, 1'b0, 1'b1);
        set_req(1'b1, M_IMM, 64'd0, 13'd4, INF);
        ADVANCE = 1'b1;
        UPDATE_SETTINGS = 1'b1;
        tick();
        ADVANCE = 1'b0;
        UPDATE_SETTINGS = 1'b0;
        expect_out("coinc_old_swap", 1'b0, 13'd0, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("coinc_new_swap", 1'b1, 13'd0, 1'b1, 1'b0, 1'b0);
        adv();
        adv();
        expect_out("coinc_run", 1'b1, 13'd2, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run discards the pending request.
        upd(1'b0, M_SYNC, 64'd0, 13'd3, 32'd0);
        expect_out("rst_pre", 1'b1, 13'd2, 1'b0, 1'b0, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 13'd0, 1'b0, 1'b1, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();
        adv();
        expect_out("rst_no_pending", 1'b0, 13'd0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
